// File: rtl/router_pkg.sv
// Shared router types and constants: VC count, allocator states, credit depth
// and the one-hot to index helper also used by the crossbar select logic.
package router_pkg;

  localparam int NUM_REQ          = 4;
  localparam int IDX_W            = $clog2(NUM_REQ);
  localparam int CREDIT_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } alloc_state_t;

  // OR-reduction form: no priority chain, valid only for zero/one-hot input
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_logic.sv
// Round-robin winner select: rotate req so ptr is bit 0, take the lowest set
// bit, rotate the one-hot result back into VC numbering.
module rr_priority_logic
  import router_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] pick;

  always_comb begin
    rot    = '0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = req[ptr + IDX_W'(k)];
    end
    pick = rot & (~rot + NUM_REQ'(1));
    for (int k = 0; k < NUM_REQ; k++) begin
      winner[ptr + IDX_W'(k)] = pick[k];
    end
  end

endmodule

// File: rtl/vc_output_allocator.sv
// Packet-granular round-robin allocator for one router output port shared by
// four input VCs, with downstream credit gating of every flit send.
//
//   state  | meaning
//   IDLE   | port free; picks a round-robin winner when en and any req
//   ACTIVE | grant held by one VC until its tail flit is sent
module vc_output_allocator
  import router_pkg::*;
#(
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  parameter int CNT_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] tail,
  input  logic               credit_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] send,
  output logic               busy,
  output logic [CNT_W-1:0]   credit_cnt,
  output logic               credit_err
);

  alloc_state_t       state;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] winner;
  logic               sending;
  logic               tail_sent;

  rr_priority_logic u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (winner)
  );

  // grant is one-hot in ACTIVE, so masking req by it selects only req[g]
  always_comb begin
    send = '0;
    if (reset && en && state == ACTIVE && credit_cnt != '0) send = grant & req;
  end

  assign sending   = |send;
  assign tail_sent = |(send & tail);
  assign busy      = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      ptr        <= '0;
      credit_cnt <= CNT_W'(CREDIT_DEPTH);
      credit_err <= 1'b0;
    end else begin
      if (en) begin
        case (state)
          IDLE: begin
            if (|req) begin
              grant <= winner;
              state <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (tail_sent) begin
              grant <= '0;
              state <= IDLE;
              ptr   <= onehot_to_idx(grant) + IDX_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end

      // credits keep counting while disabled so no returned slot is lost
      if (sending && !credit_in) begin
        credit_cnt <= credit_cnt - CNT_W'(1);
      end else if (credit_in && !sending) begin
        if (credit_cnt == CNT_W'(CREDIT_DEPTH)) credit_err <= 1'b1;
        else                                    credit_cnt <= credit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vc_output_allocator.sv
// Self-checking bench for vc_output_allocator: directed table, hand-written
// multi-cycle sequences and random traffic against an integer-level model.
module tb_vc_output_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic [3:0] tail;
  logic       credit_in;
  logic [3:0] grant;
  logic [3:0] send;
  logic       busy;
  logic [2:0] credit_cnt;
  logic       credit_err;

  vc_output_allocator dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .send       (send),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model: granted VC number (-1 = port free), rr pointer, credits, error flag
  int m_g   = -1;
  int m_ptr = 0;
  int m_cr  = 4;
  bit m_err = 1'b0;

  logic [3:0] obs_grant, obs_send;
  int         obs_cnt;
  logic       obs_err, obs_busy;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at the falling edge: drive inputs, check outputs, advance model, move to next falling edge
  task automatic cycle(input logic r, input logic e, input logic [3:0] rq,
                       input logic [3:0] tl, input logic ci);
    int  exp_send;
    int  exp_grant;
    bit  s;
    reset = r; en = e; req = rq; tail = tl; credit_in = ci;
    #1;
    exp_grant = (m_g < 0) ? 0 : (1 << m_g);
    exp_send  = (r && e && m_g >= 0 && m_cr > 0 && rq[m_g]) ? (1 << m_g) : 0;
    obs_grant = grant; obs_send = send; obs_cnt = int'(credit_cnt);
    obs_err = credit_err; obs_busy = busy;
    chk("model_grant", int'(grant), exp_grant);
    chk("model_send", int'(send), exp_send);
    chk("model_busy", int'(busy), int'(m_g >= 0));
    chk("model_credit_cnt", int'(credit_cnt), m_cr);
    chk("model_credit_err", int'(credit_err), int'(m_err));
    if (!r) begin
      m_g = -1; m_ptr = 0; m_cr = 4; m_err = 1'b0;
    end else begin
      s = (exp_send != 0);
      if (e) begin
        if (m_g < 0) begin
          for (int k = 0; k < 4; k++) begin
            if (m_g < 0 && rq[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
          end
        end else if (s && tl[m_g]) begin
          m_ptr = (m_g + 1) % 4;
          m_g   = -1;
        end
      end
      if (s && !ci) m_cr--;
      else if (ci && !s) begin
        if (m_cr == 4) m_err = 1'b1;
        else           m_cr++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] tail;
    logic       ci;
    logic [3:0] grant;
    logic [3:0] send;
    int         cnt;
  } vec_t;

  vec_t tbl[6];
  int   nsend;

  initial begin
    // reset state, then a 3-flit packet on VC0
    tbl[0] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4};
    tbl[1] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4};
    tbl[2] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4};
    tbl[3] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 3};
    tbl[4] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 2};
    tbl[5] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1};

    reset = 1'b0; en = 1'b0; req = '0; tail = '0; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].tail, tbl[i].ci);
      chk("tbl_grant", int'(obs_grant), int'(tbl[i].grant));
      chk("tbl_send", int'(obs_send), int'(tbl[i].send));
      chk("tbl_credit_cnt", obs_cnt, tbl[i].cnt);
      if (i == 0) begin
        chk("reset_busy", int'(obs_busy), 0);
        chk("reset_err", int'(obs_err), 0);
      end
    end

    // round robin: ptr now 1, single-flit packets, credit returned after each send
    repeat (3) cycle(1, 1, 4'b0000, 4'b0000, 1);
    chk("credit_restore", obs_cnt, 3);
    for (int k = 0; k < 8; k++) begin
      cycle(1, 1, 4'b1111, 4'b1111, (k % 2 == 0) && (k > 0));
      if (k % 2 == 1) chk("rr_grant", int'(obs_grant), 1 << ((1 + (k - 1) / 2) % 4));
      else            chk("rr_bubble", int'(obs_grant), 0);
    end
    cycle(1, 1, 4'b0000, 4'b0000, 1);

    // credit stall: 6-flit packet on VC2, no credits returned
    nsend = 0;
    for (int k = 0; k < 9; k++) begin
      cycle(1, 1, 4'b0100, 4'b0000, 0);
      if (obs_send != 0) nsend++;
    end
    chk("stall_sends", nsend, 4);
    chk("stall_grant", int'(obs_grant), 4'b0100);
    chk("stall_cnt", obs_cnt, 0);
    cycle(1, 1, 4'b0100, 4'b0000, 1);
    chk("stall_nosend_at_zero", int'(obs_send), 0);
    cycle(1, 1, 4'b0100, 4'b0000, 0);
    chk("stall_one_send", int'(obs_send), 4'b0100);
    cycle(1, 1, 4'b0100, 4'b0000, 0);
    chk("stall_again", int'(obs_send), 0);
    cycle(1, 1, 4'b0100, 4'b0000, 1);
    cycle(1, 1, 4'b0100, 4'b0100, 0);
    chk("stall_tail_send", int'(obs_send), 4'b0100);
    repeat (4) cycle(1, 1, 4'b0000, 4'b0000, 1);
    chk("stall_bubble_grant", int'(obs_grant), 0);

    // mid-packet events on VC1 (ptr is 3)
    cycle(1, 1, 4'b0010, 4'b0000, 0);
    cycle(1, 1, 4'b0010, 4'b0000, 0);
    chk("mid_first_send", int'(obs_send), 4'b0010);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 4'b1000, 4'b0000, 0);
      chk("mid_drop_grant", int'(obs_grant), 4'b0010);
      chk("mid_drop_send", int'(obs_send), 0);
    end
    cycle(1, 0, 4'b1010, 4'b0010, 1);
    chk("dis_send", int'(obs_send), 0);
    cycle(1, 0, 4'b1010, 4'b0010, 0);
    chk("dis_grant", int'(obs_grant), 4'b0010);
    chk("dis_credit_counts", obs_cnt, 4);
    cycle(1, 1, 4'b1010, 4'b0010, 0);
    chk("mid_tail_send", int'(obs_send), 4'b0010);
    cycle(1, 1, 4'b1000, 4'b0000, 0);
    chk("mid_bubble", int'(obs_grant), 0);
    cycle(1, 1, 4'b1000, 4'b1000, 0);
    chk("vc3_after_tail", int'(obs_grant), 4'b1000);
    cycle(1, 1, 4'b0000, 4'b0000, 0);

    // credit overflow, simultaneous send/credit, reset mid-packet
    repeat (2) cycle(1, 1, 4'b0000, 4'b0000, 1);
    cycle(1, 1, 4'b0000, 4'b0000, 1);
    cycle(1, 1, 4'b0000, 4'b0000, 0);
    chk("ovf_cnt", obs_cnt, 4);
    chk("ovf_err", int'(obs_err), 1);
    cycle(1, 1, 4'b0001, 4'b0000, 0);
    cycle(1, 1, 4'b0001, 4'b0000, 1);
    chk("both_send", int'(obs_send), 4'b0001);
    cycle(1, 1, 4'b0001, 4'b0000, 0);
    chk("both_unchanged", obs_cnt, 4);
    chk("err_sticky", int'(obs_err), 1);
    cycle(0, 1, 4'b0001, 4'b0000, 0);
    cycle(1, 1, 4'b0000, 4'b0000, 0);
    chk("rst_grant", int'(obs_grant), 0);
    chk("rst_busy", int'(obs_busy), 0);
    chk("rst_cnt", obs_cnt, 4);
    chk("rst_err", int'(obs_err), 0);

    // random traffic against the model
    for (int k = 0; k < 500; k++) begin
      cycle($urandom_range(0, 59) != 0, $urandom_range(0, 7) != 0,
            4'($urandom), 4'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
